// File: rtl/ex_operand_stage.sv
// ex_operand_stage: ID/EX pipeline register with operand forwarding and select
// logic feeding the EX-stage ALU.
//   - Captures decoded ID fields on each clock edge (priority: reset > hold >
//     flush > load-use bubble > load).
//   - Resolves RAW hazards by forwarding from EX/MEM (preferred) or MEM/WB.
//   - Detects load-use hazards and requests a one-cycle stall of PC and IF/ID.
//   - Selects shamt for in1 and the immediate for in2 when the op requires it.
// Optional feature: define STALL_COUNTER_EN to count inserted load-use bubbles
// in stall_count (saturating); otherwise stall_count is tied to zero.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   id_*                             decoded instruction fields from ID
//   flush, hold                      squash ID instruction / freeze this stage
//   mem_reg_write/mem_wreg/mem_result   EX/MEM forward source
//   wb_reg_write/wb_wreg/wb_result      MEM/WB forward source
//   stall_id                         hold PC and IF/ID this cycle
//   alu_in1, alu_in2, alu_ctl, alu_sign  ALU operands and control
//   store_data                       forwarded rt value for stores
//   ex_valid, ex_wreg, ex_reg_write, ex_mem_read  control for later stages
//   stall_count                      load-use bubble count
module ex_operand_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [4:0]        id_shamt,
    input  logic              id_src1_shamt,
    input  logic              id_src2_imm,
    input  logic [4:0]        id_alu_ctl,
    input  logic              id_sign,
    input  logic [REG_AW-1:0] id_wreg,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              flush,
    input  logic              hold,
    input  logic              mem_reg_write,
    input  logic [REG_AW-1:0] mem_wreg,
    input  logic [DATA_W-1:0] mem_result,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_wreg,
    input  logic [DATA_W-1:0] wb_result,
    output logic              stall_id,
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    output logic [4:0]        alu_ctl,
    output logic              alu_sign,
    output logic [DATA_W-1:0] store_data,
    output logic              ex_valid,
    output logic [REG_AW-1:0] ex_wreg,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic [CNT_W-1:0]  stall_count
);

    logic [REG_AW-1:0] ex_rs;
    logic [REG_AW-1:0] ex_rt;
    logic [DATA_W-1:0] ex_rs_data;
    logic [DATA_W-1:0] ex_rt_data;
    logic [DATA_W-1:0] ex_imm;
    logic [4:0]        ex_shamt;
    logic              ex_src1_shamt;
    logic              ex_src2_imm;
    logic [DATA_W-1:0] fwd_rs;
    logic [DATA_W-1:0] fwd_rt;
    logic              load_use;

    // Load-use hazard: the EX instruction is a load whose result ID needs now.
    always_comb begin
        load_use = 1'b0;
        if (id_valid && ex_valid && ex_mem_read && (ex_wreg != '0)) begin
            load_use = (id_use_rs && (id_rs == ex_wreg)) ||
                       (id_use_rt && (id_rt == ex_wreg));
        end
    end

    assign stall_id = load_use | hold;

    // Forwarding muxes; EX/MEM is younger so it wins, r0 is never forwarded.
    always_comb begin
        fwd_rs = ex_rs_data;
        if (ex_rs != '0) begin
            if (mem_reg_write && (mem_wreg == ex_rs))     fwd_rs = mem_result;
            else if (wb_reg_write && (wb_wreg == ex_rs))  fwd_rs = wb_result;
        end
        fwd_rt = ex_rt_data;
        if (ex_rt != '0) begin
            if (mem_reg_write && (mem_wreg == ex_rt))     fwd_rt = mem_result;
            else if (wb_reg_write && (wb_wreg == ex_rt))  fwd_rt = wb_result;
        end
    end

    assign alu_in1    = ex_src1_shamt ? DATA_W'(ex_shamt) : fwd_rs;
    assign alu_in2    = ex_src2_imm ? ex_imm : fwd_rt;
    assign store_data = fwd_rt;

    // ID/EX register. Hold refreshes the operand data so a WB write landing
    // during the freeze is not lost once its forward source retires.
    always_ff @(posedge clk) begin
        if (reset || (!hold && (flush || load_use))) begin
            ex_valid      <= 1'b0;
            ex_rs         <= '0;
            ex_rt         <= '0;
            ex_rs_data    <= '0;
            ex_rt_data    <= '0;
            ex_imm        <= '0;
            ex_shamt      <= '0;
            ex_src1_shamt <= 1'b0;
            ex_src2_imm   <= 1'b0;
            alu_ctl       <= '0;
            alu_sign      <= 1'b0;
            ex_wreg       <= '0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
        end else if (hold) begin
            ex_rs_data <= fwd_rs;
            ex_rt_data <= fwd_rt;
        end else begin
            ex_valid      <= id_valid;
            ex_rs         <= id_rs;
            ex_rt         <= id_rt;
            ex_rs_data    <= id_rs_data;
            ex_rt_data    <= id_rt_data;
            ex_imm        <= id_imm;
            ex_shamt      <= id_shamt;
            ex_src1_shamt <= id_src1_shamt;
            ex_src2_imm   <= id_src2_imm;
            alu_ctl       <= id_alu_ctl;
            alu_sign      <= id_sign;
            ex_wreg       <= id_wreg;
            // Control that changes machine state is qualified by a real instruction.
            ex_reg_write  <= id_valid & id_reg_write;
            ex_mem_read   <= id_valid & id_mem_read;
        end
    end

`ifdef STALL_COUNTER_EN
    logic [CNT_W-1:0] stall_cnt_q;

    // Saturating count of bubbles actually inserted for load-use.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (load_use && !hold && !flush && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign stall_count = stall_cnt_q;
`else
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_ex_operand_stage.sv
// Testbench for ex_operand_stage: a table of single-instruction vectors with
// hand-computed ALU operands, plus directed sequences for reset, load-use,
// hold-with-writeback and mid-stream reset.
module tb_ex_operand_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs, id_rt;
    logic        id_use_rs, id_use_rt;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_shamt;
    logic        id_src1_shamt, id_src2_imm;
    logic [4:0]  id_alu_ctl;
    logic        id_sign;
    logic [4:0]  id_wreg;
    logic        id_reg_write, id_mem_read;
    logic        flush, hold;
    logic        mem_reg_write;
    logic [4:0]  mem_wreg;
    logic [31:0] mem_result;
    logic        wb_reg_write;
    logic [4:0]  wb_wreg;
    logic [31:0] wb_result;
    logic        stall_id;
    logic [31:0] alu_in1, alu_in2, store_data;
    logic [4:0]  alu_ctl;
    logic        alu_sign;
    logic        ex_valid;
    logic [4:0]  ex_wreg;
    logic        ex_reg_write, ex_mem_read;
    logic [31:0] stall_count;

    int n_vec = 0;
    int n_err = 0;

    ex_operand_stage dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_shamt(id_shamt), .id_src1_shamt(id_src1_shamt), .id_src2_imm(id_src2_imm),
        .id_alu_ctl(id_alu_ctl), .id_sign(id_sign), .id_wreg(id_wreg),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .flush(flush), .hold(hold),
        .mem_reg_write(mem_reg_write), .mem_wreg(mem_wreg), .mem_result(mem_result),
        .wb_reg_write(wb_reg_write), .wb_wreg(wb_wreg), .wb_result(wb_result),
        .stall_id(stall_id), .alu_in1(alu_in1), .alu_in2(alu_in2),
        .alu_ctl(alu_ctl), .alu_sign(alu_sign), .store_data(store_data),
        .ex_valid(ex_valid), .ex_wreg(ex_wreg), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [4:0]  shamt;
        logic        src1;
        logic        src2;
        logic [4:0]  ctl;
        logic        flush;
        logic        mem_rw;
        logic [4:0]  mem_wreg;
        logic [31:0] mem_res;
        logic        wb_rw;
        logic [4:0]  wb_wreg;
        logic [31:0] wb_res;
        logic [31:0] exp_in1;
        logic [31:0] exp_in2;
        logic [31:0] exp_sd;
        logic [4:0]  exp_ctl;
        logic        exp_valid;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_valid = 1'b0; id_rs = '0; id_rt = '0; id_use_rs = 1'b0; id_use_rt = 1'b0;
        id_rs_data = '0; id_rt_data = '0; id_imm = '0; id_shamt = '0;
        id_src1_shamt = 1'b0; id_src2_imm = 1'b0; id_alu_ctl = '0; id_sign = 1'b0;
        id_wreg = '0; id_reg_write = 1'b0; id_mem_read = 1'b0;
        flush = 1'b0; hold = 1'b0;
        mem_reg_write = 1'b0; mem_wreg = '0; mem_result = '0;
        wb_reg_write = 1'b0; wb_wreg = '0; wb_result = '0;
    endtask

    initial begin
        vecs[0] = '{rs: 5'd1, rt: 5'd2, rs_data: 32'd10, rt_data: 32'd20, ctl: 5'd2,
                    exp_in1: 32'd10, exp_in2: 32'd20, exp_sd: 32'd20, exp_ctl: 5'd2,
                    exp_valid: 1'b1, default: '0};
        vecs[1] = '{rs: 5'd5, rt: 5'd6, rs_data: 32'h100, rt_data: 32'h200, ctl: 5'd2,
                    mem_rw: 1'b1, mem_wreg: 5'd5, mem_res: 32'h11,
                    wb_rw: 1'b1, wb_wreg: 5'd5, wb_res: 32'h22,
                    exp_in1: 32'h11, exp_in2: 32'h200, exp_sd: 32'h200, exp_ctl: 5'd2,
                    exp_valid: 1'b1, default: '0};
        vecs[2] = '{rs: 5'd5, rt: 5'd6, rs_data: 32'h100, rt_data: 32'h200, ctl: 5'd2,
                    wb_rw: 1'b1, wb_wreg: 5'd5, wb_res: 32'h22,
                    exp_in1: 32'h22, exp_in2: 32'h200, exp_sd: 32'h200, exp_ctl: 5'd2,
                    exp_valid: 1'b1, default: '0};
        vecs[3] = '{rs: 5'd0, rt: 5'd0, ctl: 5'd3,
                    mem_rw: 1'b1, mem_wreg: 5'd0, mem_res: 32'hFFFF,
                    exp_ctl: 5'd3, exp_valid: 1'b1, default: '0};
        vecs[4] = '{rt: 5'd2, rt_data: 32'h8, shamt: 5'd4, src1: 1'b1, ctl: 5'd8,
                    exp_in1: 32'd4, exp_in2: 32'h8, exp_sd: 32'h8, exp_ctl: 5'd8,
                    exp_valid: 1'b1, default: '0};
        vecs[5] = '{rs: 5'd1, rt: 5'd9, rs_data: 32'h1200, rt_data: 32'h55,
                    imm: 32'h00FF, src2: 1'b1, ctl: 5'd5,
                    exp_in1: 32'h1200, exp_in2: 32'hFF, exp_sd: 32'h55, exp_ctl: 5'd5,
                    exp_valid: 1'b1, default: '0};
        vecs[6] = '{rs: 5'd1, rt: 5'd7, rs_data: 32'h40, rt_data: 32'h1,
                    imm: 32'h4, src2: 1'b1, ctl: 5'd2,
                    mem_rw: 1'b1, mem_wreg: 5'd7, mem_res: 32'hDEAD,
                    exp_in1: 32'h40, exp_in2: 32'h4, exp_sd: 32'hDEAD, exp_ctl: 5'd2,
                    exp_valid: 1'b1, default: '0};
        vecs[7] = '{rs: 5'd1, rt: 5'd2, rs_data: 32'h77, rt_data: 32'h88, ctl: 5'd2,
                    flush: 1'b1, default: '0};

        clear_inputs();
        reset = 1'b1;
        step();
        step();
        check("reset_ex_valid", 32'(ex_valid), 32'd0);
        check("reset_ex_reg_write", 32'(ex_reg_write), 32'd0);
        check("reset_alu_ctl", 32'(alu_ctl), 32'd0);
        check("reset_stall_id", 32'(stall_id), 32'd0);
        check("reset_stall_count", stall_count, 32'd0);
        reset = 1'b0;

        // Table of single-instruction vectors.
        for (int i = 0; i < 8; i++) begin
            id_valid = 1'b1; id_use_rs = 1'b1; id_use_rt = 1'b1;
            id_rs = vecs[i].rs; id_rt = vecs[i].rt;
            id_rs_data = vecs[i].rs_data; id_rt_data = vecs[i].rt_data;
            id_imm = vecs[i].imm; id_shamt = vecs[i].shamt;
            id_src1_shamt = vecs[i].src1; id_src2_imm = vecs[i].src2;
            id_alu_ctl = vecs[i].ctl; id_wreg = 5'd10; id_reg_write = 1'b1;
            id_mem_read = 1'b0; flush = vecs[i].flush;
            mem_reg_write = vecs[i].mem_rw; mem_wreg = vecs[i].mem_wreg;
            mem_result = vecs[i].mem_res;
            wb_reg_write = vecs[i].wb_rw; wb_wreg = vecs[i].wb_wreg;
            wb_result = vecs[i].wb_res;
            step();
            check($sformatf("v%0d_alu_in1", i), alu_in1, vecs[i].exp_in1);
            check($sformatf("v%0d_alu_in2", i), alu_in2, vecs[i].exp_in2);
            check($sformatf("v%0d_store_data", i), store_data, vecs[i].exp_sd);
            check($sformatf("v%0d_alu_ctl", i), 32'(alu_ctl), 32'(vecs[i].exp_ctl));
            check($sformatf("v%0d_ex_valid", i), 32'(ex_valid), 32'(vecs[i].exp_valid));
            check($sformatf("v%0d_ex_reg_write", i), 32'(ex_reg_write), 32'(vecs[i].exp_valid));
            check($sformatf("v%0d_stall_id", i), 32'(stall_id), 32'd0);
        end
        flush = 1'b0;

        // Load-use: lw $3 in EX, add $4,$3,$1 in ID.
        clear_inputs();
        id_valid = 1'b1; id_rs = 5'd1; id_use_rs = 1'b1; id_rs_data = 32'h40;
        id_imm = 32'h8; id_src2_imm = 1'b1; id_alu_ctl = 5'd2;
        id_wreg = 5'd3; id_reg_write = 1'b1; id_mem_read = 1'b1;
        step();
        check("lw_ex_mem_read", 32'(ex_mem_read), 32'd1);
        id_rs = 5'd3; id_rt = 5'd1; id_use_rs = 1'b1; id_use_rt = 1'b1;
        id_rs_data = 32'h0; id_rt_data = 32'h5; id_imm = '0; id_src2_imm = 1'b0;
        id_wreg = 5'd4; id_mem_read = 1'b0;
        #1;
        check("lu_stall_id", 32'(stall_id), 32'd1);
        step();
        check("lu_bubble_valid", 32'(ex_valid), 32'd0);
        check("lu_bubble_reg_write", 32'(ex_reg_write), 32'd0);
        check("lu_bubble_alu_ctl", 32'(alu_ctl), 32'd0);
        check("lu_stall_released", 32'(stall_id), 32'd0);
        mem_reg_write = 1'b1; mem_wreg = 5'd3; mem_result = 32'h77;
        step();
        check("lu_add_valid", 32'(ex_valid), 32'd1);
        check("lu_add_in1_fwd", alu_in1, 32'h77);
        check("lu_add_in2", alu_in2, 32'h5);
        check("lu_add_wreg", 32'(ex_wreg), 32'd4);
`ifdef STALL_COUNTER_EN
        check("lu_stall_count", stall_count, 32'd1);
`else
        check("lu_stall_count", stall_count, 32'd0);
`endif

        // Hold for two cycles while WB writes rt=7.
        clear_inputs();
        id_valid = 1'b1; id_rs = 5'd2; id_rt = 5'd7; id_use_rs = 1'b1; id_use_rt = 1'b1;
        id_rs_data = 32'h3; id_rt_data = 32'h1; id_alu_ctl = 5'd6;
        id_wreg = 5'd8; id_reg_write = 1'b1;
        step();
        check("hold_pre_in2", alu_in2, 32'h1);
        hold = 1'b1;
        id_alu_ctl = 5'd9; id_rt_data = 32'h2;
        wb_reg_write = 1'b1; wb_wreg = 5'd7; wb_result = 32'hABCD;
        #1;
        check("hold_stall_id", 32'(stall_id), 32'd1);
        step();
        wb_reg_write = 1'b0; wb_result = '0;
        step();
        hold = 1'b0;
        #1;
        check("hold_post_in2", alu_in2, 32'hABCD);
        check("hold_post_store", store_data, 32'hABCD);
        check("hold_post_alu_ctl", 32'(alu_ctl), 32'd6);
        check("hold_post_valid", 32'(ex_valid), 32'd1);

        // Reset mid-stream with a live instruction presented.
        id_mem_read = 1'b1;
        reset = 1'b1;
        step();
        check("mid_reset_valid", 32'(ex_valid), 32'd0);
        check("mid_reset_alu_ctl", 32'(alu_ctl), 32'd0);
        check("mid_reset_reg_write", 32'(ex_reg_write), 32'd0);
        check("mid_reset_stall_id", 32'(stall_id), 32'd0);
        check("mid_reset_alu_in1", alu_in1, 32'd0);
        check("mid_reset_stall_count", stall_count, 32'd0);
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
